pipelined_addsub: RTL and testbench

Parametrised, pipelined successor to the team's 8-bit two-stage CLA-chained adder. It computes a WIDTH-bit add, subtract, add-with-carry or subtract-with-borrow, one SLICE-bit carry-lookahead slice per pipeline stage, with the carry registered between stages. A valid/ready handshake with backpressure and full ALU flags let it drop straight into the Octa16 execute stage or serve as a standalone arithmetic unit.

---
 rtl/pipelined_addsub.sv | 134 +++++++++++++
 tb/tb_pipelined_addsub.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/sub/adc/sbb: one SLICE-bit carry-lookahead slice per stage,
// carry registered between stages, global valid/ready stall, registered ALU flags.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NSTG = WIDTH / SLICE;
  localparam int LAST = NSTG - 1;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // op[0] selects subtraction; op[1] takes the external carry/borrow-in
  always_comb begin
    b_eff = op[0] ? ~b : b;
    c0    = op[1] ? cin : op[0];
  end

  // Returns {carry_out, sum_slice}; carries are expanded as generate/propagate products
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             ci);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & ci);
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  // Each stage carries only the operand bits not yet consumed and the sum bits already produced
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int AW = WIDTH - k * SLICE;

    logic [AW-1:0]           a_cur;
    logic [AW-1:0]           b_cur;
    logic                    c_cur;
    logic                    v_cur;
    logic [SLICE:0]          res;
    logic [(k+1)*SLICE-1:0]  s_out;

    assign res = cla_slice(a_cur[SLICE-1:0], b_cur[SLICE-1:0], c_cur);

    if (k == 0) begin : g_in
      assign a_cur = a;
      assign b_cur = b_eff;
      assign c_cur = c0;
      assign v_cur = in_valid & in_ready;
      assign s_out = res[SLICE-1:0];
    end else begin : g_reg
      logic [k*SLICE-1:0] s_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_cur <= '0;
          b_cur <= '0;
          c_cur <= 1'b0;
          v_cur <= 1'b0;
          s_q   <= '0;
        end else if (adv) begin
          a_cur <= g_stg[k-1].a_cur[AW+SLICE-1:SLICE];
          b_cur <= g_stg[k-1].b_cur[AW+SLICE-1:SLICE];
          c_cur <= g_stg[k-1].res[SLICE];
          v_cur <= g_stg[k-1].v_cur;
          s_q   <= g_stg[k-1].s_out;
        end
      end

      assign s_out = {res[SLICE-1:0], s_q};
    end
  end

  logic [WIDTH-1:0] full;
  logic             c_msb_in;

  assign full     = g_stg[LAST].s_out;
  // Carry into the MSB recovered from the MSB sum bit and its operand bits
  assign c_msb_in = full[WIDTH-1] ^ g_stg[LAST].a_cur[SLICE-1] ^ g_stg[LAST].b_cur[SLICE-1];

  // Bubbles clear out_valid but leave the last result and flags on the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (adv) begin
      out_valid <= g_stg[LAST].v_cur;
      if (g_stg[LAST].v_cur) begin
        sum  <= full;
        cout <= g_stg[LAST].res[SLICE];
        ovf  <= c_msb_in ^ g_stg[LAST].res[SLICE];
        zero <= (full == '0);
        neg  <= full[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, streaming with backpressure, async reset,
// and a random sweep of four parameterisations against an arithmetic reference model.
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic [1:0]  op;
  logic        cin, cout, ovf, zero, neg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  // Sweep instances: (8,4) (16,8) (32,4) (8,8)
  localparam int NOPS = 10000;
  int          sw_w[4]    = '{8, 16, 32, 8};
  int          sw_nstg[4] = '{2, 2, 8, 1};
  logic        sw_iv[4], sw_ir[4], sw_ov[4], sw_or[4], sw_cin[4];
  logic [1:0]  sw_op[4];
  logic [31:0] sw_a[4], sw_b[4], sw_sum[4];
  logic        sw_co[4], sw_of[4], sw_z[4], sw_neg[4];
  logic [35:0] expq[4][64];
  logic        expv[4][64];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 32 : 8;
    localparam int S = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 4 : 8;
    logic [W-1:0] s_w;
    pipelined_addsub #(.WIDTH(W), .SLICE(S)) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_iv[g]), .in_ready(sw_ir[g]),
      .a(sw_a[g][W-1:0]), .b(sw_b[g][W-1:0]), .op(sw_op[g]), .cin(sw_cin[g]),
      .out_valid(sw_ov[g]), .out_ready(sw_or[g]),
      .sum(s_w), .cout(sw_co[g]), .ovf(sw_of[g]), .zero(sw_z[g]), .neg(sw_neg[g])
    );
    assign sw_sum[g] = 32'(s_w);
  end

  // Reference: plain integer arithmetic; returns {neg, zero, ovf, cout, sum[31:0]}
  function automatic logic [35:0] ref_op(input int w, input logic [1:0] o,
                                         input logic [31:0] x, input logic [31:0] y,
                                         input logic ci);
    longint m, lim, ux, uy, sx, sy, r, rs, cl, br;
    logic co, ov;
    logic [31:0] s;
    m   = (longint'(1) << w) - 1;
    lim = longint'(1) << (w - 1);
    ux  = longint'(x) & m;
    uy  = longint'(y) & m;
    sx  = (ux >= lim) ? ux - 2 * lim : ux;
    sy  = (uy >= lim) ? uy - 2 * lim : uy;
    cl  = ci ? 1 : 0;
    br  = ci ? 0 : 1;
    case (o)
      2'd0:    begin r = ux + uy;      rs = sx + sy;      co = (r > m);          end
      2'd1:    begin r = ux - uy;      rs = sx - sy;      co = (ux >= uy);       end
      2'd2:    begin r = ux + uy + cl; rs = sx + sy + cl; co = (r > m);          end
      default: begin r = ux - uy - br; rs = sx - sy - br; co = (ux >= uy + br);  end
    endcase
    s  = 32'(r & m);
    ov = (rs >= lim) || (rs < -lim);
    return {s[w-1], (s == 32'd0), ov, co, s};
  endfunction

  task automatic issue_wait(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                            input logic ci, output int lat, output logic [35:0] obs);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; cin = ci;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    obs = {neg, zero, ovf, cout, 16'h0, sum};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    total++;
    if ({sum, cout, ovf, zero, neg} !== 20'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 00000", {sum, cout, ovf, zero, neg});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed;
    logic [1:0]  vo[6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
    logic [15:0] va[6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0003, 16'h0005, 16'h00FF};
    logic [15:0] vb[6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0005, 16'h0003, 16'h0F00};
    logic        vc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [35:0] ve[6] = '{{4'b0000, 32'h5555}, {4'b0101, 32'h0000}, {4'b1010, 32'h8000},
                           {4'b1000, 32'hFFFE}, {4'b0001, 32'h0001}, {4'b0000, 32'h1000}};
    int lat;
    logic [35:0] obs;
    for (int i = 0; i < 6; i++) begin
      issue_wait(vo[i], va[i], vb[i], vc[i], lat, obs);
      total++;
      if (lat != 4) begin
        bad++; $display("FAIL directed%0d_latency: got %0d want 4", i, lat);
      end
      total++;
      if (obs !== ve[i]) begin
        bad++; $display("FAIL directed%0d_result: got %h want %h", i, obs, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] xs[8], ys[8];
    logic [35:0] ex[8];
    logic [35:0] obs, held;
    int issued = 0, got = 0, cyc = 0;
    logic seen = 1'b0, gap = 1'b0;
    held = '0;
    for (int i = 0; i < 8; i++) begin
      xs[i] = 16'($urandom);
      ys[i] = 16'($urandom);
      ex[i] = ref_op(16, 2'd0, 32'(xs[i]), 32'(ys[i]), 1'b0);
    end
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (issued < 8);
      if (issued < 8) begin
        a = xs[issued]; b = ys[issued]; op = 2'd0; cin = 1'($urandom);
      end
      #1;
      obs = {neg, zero, ovf, cout, 16'h0, sum};
      if (cyc >= 6 && cyc <= 8) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++; $display("FAIL b2b_stall_in_ready cyc%0d: got %b want 0", cyc, in_ready);
        end
        if (cyc == 6) held = obs;
        else begin
          total++;
          if (obs !== held) begin
            bad++; $display("FAIL b2b_hold cyc%0d: got %h want %h", cyc, obs, held);
          end
        end
      end
      if (out_valid) seen = 1'b1;
      else if (seen) gap = 1'b1;
      if (out_valid && out_ready) begin
        total++;
        if (obs !== ex[got]) begin
          bad++; $display("FAIL b2b_result%0d: got %h want %h", got, obs, ex[got]);
        end
        got++;
      end
      if (in_valid && in_ready) issued++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got != 8) begin
      bad++; $display("FAIL b2b_count: got %0d want 8", got);
    end
    total++;
    if (gap !== 1'b0) begin
      bad++; $display("FAIL b2b_gap: got %b want 0", gap);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_async_reset;
    int lat;
    logic [35:0] obs, ex;
    logic stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 2'd0; a = 16'h1111 + 16'(i); b = 16'h0101; cin = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL arst_pre_valid: got %b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL arst_out_valid: got %b want 0", out_valid);
    end
    total++;
    if ({sum, cout, ovf, zero, neg} !== 20'h0) begin
      bad++; $display("FAIL arst_outputs: got %h want 00000", {sum, cout, ovf, zero, neg});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
    end
    total++;
    if (stray !== 1'b0) begin
      bad++; $display("FAIL arst_stale_result: got %b want 0", stray);
    end
    ex = ref_op(16, 2'd1, 32'h0100, 32'h0001, 1'b0);
    issue_wait(2'd1, 16'h0100, 16'h0001, 1'b0, lat, obs);
    total++;
    if (lat != 4 || obs !== ex) begin
      bad++; $display("FAIL arst_new_op: got lat=%0d %h want lat=4 %h", lat, obs, ex);
    end
  endtask

  task automatic test_param_sweep;
    logic [35:0] obs;
    int slot;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 64; j++) expv[i][j] = 1'b0;
    for (int cyc = 0; cyc < NOPS + 16; cyc++) begin
      @(negedge clk);
      slot = cyc % 64;
      for (int i = 0; i < 4; i++) begin
        obs = {sw_neg[i], sw_z[i], sw_of[i], sw_co[i], sw_sum[i]};
        total++;
        if (sw_ov[i] !== expv[i][slot]) begin
          bad++;
          $display("FAIL sweep%0d_valid cyc%0d: got %b want %b", i, cyc, sw_ov[i], expv[i][slot]);
        end else if (expv[i][slot]) begin
          total++;
          if (obs !== expq[i][slot]) begin
            bad++;
            $display("FAIL sweep%0d_result cyc%0d: got %h want %h", i, cyc, obs, expq[i][slot]);
          end
        end
        expv[i][slot] = 1'b0;
        sw_iv[i]  = (cyc < NOPS) && ($urandom_range(0, 9) != 0);
        sw_a[i]   = $urandom;
        sw_b[i]   = $urandom;
        sw_op[i]  = 2'($urandom);
        sw_cin[i] = 1'($urandom);
        if (sw_iv[i]) begin
          expq[i][(cyc + sw_nstg[i]) % 64] = ref_op(sw_w[i], sw_op[i], sw_a[i], sw_b[i], sw_cin[i]);
          expv[i][(cyc + sw_nstg[i]) % 64] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 2'd0; cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sw_iv[i] = 1'b0; sw_or[i] = 1'b1; sw_cin[i] = 1'b0;
      sw_op[i] = 2'd0; sw_a[i] = '0; sw_b[i] = '0;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
